// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - ALU/MDU control decoder with registered handshake and MUL/DIV latency sequencing
// Decodes ALUOp/funct fields into ALUControl; M-extension ops hold the block busy until the MDU result is due.
module alu_ctrl_seq #(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUOp,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic              funct7_0,
  input  logic              is_imm,
  output logic              out_valid,
  output logic [CTRL_W-1:0] ALUControl,
  output logic [2:0]        md_op,
  output logic              busy,
  output logic              illegal
);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLTU = 4'b1000;
  localparam logic [3:0] C_XOR  = 4'b1001;
  localparam logic [3:0] C_SLL  = 4'b1010;
  localparam logic [3:0] C_SRL  = 4'b1011;
  localparam logic [3:0] C_SRA  = 4'b1100;
  localparam logic [3:0] C_MUL  = 4'b1101;
  localparam logic [3:0] C_DIV  = 4'b1110;
  localparam logic [3:0] C_ILL  = 4'b1111;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [3:0]       r_code, w_code;
  logic [2:0]       r_md_op, w_md_op;
  logic             r_illegal, w_illegal;
  logic             w_is_md;
  logic             w_load;

  always_comb begin
    w_code    = C_ADD;
    w_md_op   = 3'b000;
    w_is_md   = 1'b0;
    w_illegal = 1'b0;
    case (ALUOp)
      2'b00: w_code = C_ADD;
      2'b01: w_code = C_SUB;
      2'b11: begin
        w_code    = C_ILL;
        w_illegal = 1'b1;
      end
      default: begin
        // funct7_0 only selects the M-extension on register-register ops
        if (!is_imm && funct7_0) begin
          w_is_md = 1'b1;
          w_md_op = funct3;
          w_code  = funct3[2] ? C_DIV : C_MUL;
        end else begin
          case (funct3)
            3'b000:  w_code = (funct7_5 && !is_imm) ? C_SUB : C_ADD;
            3'b001:  w_code = C_SLL;
            3'b010:  w_code = C_SLT;
            3'b011:  w_code = C_SLTU;
            3'b100:  w_code = C_XOR;
            3'b101:  w_code = funct7_5 ? C_SRA : C_SRL;
            3'b110:  w_code = C_OR;
            default: w_code = C_AND;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_out_valid_nxt = 1'b0;
    w_load          = 1'b0;
    in_ready        = (r_state == S_IDLE);
    busy            = (r_state == S_BUSY);
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            w_load = 1'b1;
            if (w_is_md) begin
              w_state_nxt = S_BUSY;
              w_cnt_nxt   = w_md_op[2] ? DIV_LOAD : MUL_LOAD;
            end else begin
              w_out_valid_nxt = 1'b1;
            end
          end
        end
        default: begin
          if (r_cnt == '0) begin
            w_state_nxt     = S_IDLE;
            w_out_valid_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_code      <= C_ADD;
      r_md_op     <= 3'b000;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      // operation fields stay frozen through BUSY, the result pulse and any flush
      if (w_load) begin
        r_code    <= w_code;
        r_md_op   <= w_md_op;
        r_illegal <= w_illegal;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign ALUControl = CTRL_W'(r_code);
  assign md_op      = r_md_op;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - directed self-checking bench for alu_ctrl_seq
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] ALUOp;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       funct7_0;
  logic       is_imm;
  logic       out_valid;
  logic [3:0] ALUControl;
  logic [2:0] md_op;
  logic       busy;
  logic       illegal;

  int n_checks = 0;
  int n_errors = 0;

  alu_ctrl_seq #(
    .CTRL_W(4), .MUL_CYCLES(2), .DIV_CYCLES(32), .CNT_W(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUOp(ALUOp), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0), .is_imm(is_imm),
    .out_valid(out_valid), .ALUControl(ALUControl), .md_op(md_op),
    .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                       input logic f70, input logic imm);
    in_valid = 1'b1;
    ALUOp    = op;
    funct3   = f3;
    funct7_5 = f75;
    funct7_0 = f70;
    is_imm   = imm;
  endtask

  logic [2:0] b2b_f3  [4] = '{3'b011, 3'b100, 3'b101, 3'b111};
  logic       b2b_f75 [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [3:0] b2b_exp [4] = '{4'b1000, 4'b1001, 4'b1100, 4'b0000};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int pulses;
    rst_n = 1'b0; flush = 1'b0;
    in_valid = 1'b0; ALUOp = 2'b00; funct3 = 3'b000;
    funct7_5 = 1'b0; funct7_0 = 1'b0; is_imm = 1'b0;
    tick(); tick();
    chk("rst_alu", ALUControl, 4'b0010);
    chk("rst_ov", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_md", md_op, 0);
    chk("rst_ill", illegal, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", in_ready, 1);

    apply(2'b10, 3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    apply(2'b10, 3'b000, 1'b1, 1'b0, 1'b1);
    chk("sub_ov", out_valid, 1);
    chk("sub_alu", ALUControl, 4'b0110);
    tick();
    in_valid = 1'b0;
    chk("addi_ov", out_valid, 1);
    chk("addi_alu", ALUControl, 4'b0010);
    tick();
    chk("idle_ov", out_valid, 0);

    for (int i = 0; i < 4; i++) begin
      apply(2'b10, b2b_f3[i], b2b_f75[i], 1'b0, 1'b0);
      tick();
      if (i == 3) in_valid = 1'b0;
      chk($sformatf("b2b%0d_ov", i), out_valid, 1);
      chk($sformatf("b2b%0d_alu", i), ALUControl, b2b_exp[i]);
    end
    tick();

    apply(2'b10, 3'b000, 1'b0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("mul_c1_busy", busy, 1);
    chk("mul_c1_ready", in_ready, 0);
    chk("mul_c1_ov", out_valid, 0);
    tick();
    chk("mul_c2_busy", busy, 1);
    chk("mul_c2_ov", out_valid, 0);
    tick();
    chk("mul_ov", out_valid, 1);
    chk("mul_busy", busy, 0);
    chk("mul_alu", ALUControl, 4'b1101);
    chk("mul_md", md_op, 3'b000);
    tick();

    apply(2'b10, 3'b101, 1'b0, 1'b1, 1'b0);
    tick();
    apply(2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    k = 1;
    while (!out_valid && k < 40) begin
      if (k == 16) begin
        chk("divu_mid_busy", busy, 1);
        chk("divu_mid_alu", ALUControl, 4'b1110);
        chk("divu_mid_md", md_op, 3'b101);
      end
      tick();
      k++;
    end
    chk("divu_latency", k, 33);
    chk("divu_alu", ALUControl, 4'b1110);
    chk("divu_md", md_op, 3'b101);
    chk("divu_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("held_ov", out_valid, 1);
    chk("held_alu", ALUControl, 4'b0010);
    chk("held_md", md_op, 3'b000);
    tick();

    apply(2'b10, 3'b100, 1'b0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("fl_pre_busy", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_busy", busy, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_ov", out_valid, 0);
    chk("fl_alu_hold", ALUControl, 4'b1110);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    chk("fl_no_pulse", pulses, 0);

    apply(2'b11, 3'b000, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_req_ov", out_valid, 0);
    chk("fl_req_ill", illegal, 0);
    tick();

    apply(2'b10, 3'b110, 1'b0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb_busy", busy, 0);
    chk("rb_ready", in_ready, 1);
    chk("rb_alu", ALUControl, 4'b0010);
    chk("rb_md", md_op, 3'b000);
    chk("rb_ov", out_valid, 0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    chk("rb_no_pulse", pulses, 0);

    apply(2'b11, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    apply(2'b10, 3'b110, 1'b0, 1'b1, 1'b1);
    chk("ill_ov", out_valid, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_alu", ALUControl, 4'b1111);
    tick();
    in_valid = 1'b0;
    chk("ori_ov", out_valid, 1);
    chk("ori_alu", ALUControl, 4'b0001);
    chk("ori_busy", busy, 0);
    chk("ori_ill", illegal, 0);
    chk("ori_md", md_op, 3'b000);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Parametrised successor to the single-cycle ALU control decoder. Decodes ALUOp/funct3/funct7 into a widened ALUControl covering the full RV32I ALU set plus the M-extension. The output is registered behind a valid/ready handshake. Sits between the main control unit and the ALU/MDU of the multi-cycle core. It also sequences multi-cycle MUL/DIV operations with a latency counter, holding off new requests until the MDU result is due.

Parameters:
CTRL_W, 4, ALUControl width; must be >= 4; upper bits beyond [3:0] are driven 0.
MUL_CYCLES, 2, MDU multiply latency in cycles; must be >= 1.
DIV_CYCLES, 32, MDU divide/remainder latency in cycles; must be >= 1.
CNT_W, 6, latency counter width; must hold max(MUL_CYCLES, DIV_CYCLES)-1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous abort; returns block to IDLE
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
ALUOp  input  2  00 add (ld/st), 01 sub (branch), 10 decode funct fields, 11 reserved
funct3  input  3  instruction funct3
funct7_5  input  1  instruction bit 30
funct7_0  input  1  instruction bit 25 (M-extension select)
is_imm  input  1  1 = OP-IMM instruction
out_valid  output  1  one-cycle pulse: ALUControl/md_op valid and result due
ALUControl  output  CTRL_W  registered ALU operation code
md_op  output  3  registered funct3 of the M op (MUL/MULH/.../REMU); 0 otherwise
busy  output  1  multi-cycle op in progress
illegal  output  1  registered; qualifies out_valid for undecodable requests

Behaviour:
- Codes, zero-extended to CTRL_W:
  - Legacy 3-bit values preserved: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111.
  - New: SLTU 1000, XOR 1001, SLL 1010, SRL 1011, SRA 1100, MUL-class 1101, DIV-class 1110, ILLEGAL 1111.
- Decode:
  - ALUOp 00 -> ADD. ALUOp 01 -> SUB. ALUOp 11 -> ILLEGAL with illegal=1.
  - ALUOp 10 with funct3: 000 -> SUB if (funct7_5 & !is_imm), else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 -> SRA if funct7_5, else SRL; 110 OR; 111 AND.
  - M op only when ALUOp=10 & !is_imm & funct7_0. funct3[2]=0 -> MUL-class, 1 -> DIV-class, md_op=funct3. With is_imm=1, funct7_0 is ignored.
- Reset (async, rst_n=0): state IDLE, counter 0, ALUControl=0010 (ADD), md_op=0, out_valid=0, illegal=0, busy=0. in_ready=1 after reset release.
- States:
  - IDLE: in_ready=1, busy=0.
    - Accept on in_valid & in_ready at edge T; ALUControl/md_op/illegal register at T.
    - Base op: out_valid=1 during cycle T+1 (latency 1); stay IDLE. Back-to-back accepts are allowed every cycle.
    - M op: out_valid stays 0; counter loads N-1 (N=MUL_CYCLES or DIV_CYCLES); go BUSY.
  - BUSY: in_ready=0, busy=1, out_valid=0; counter decrements each cycle.
    - At counter==0: go IDLE and pulse out_valid for 1 cycle. Total M latency from accept = N+1 cycles.
    - ALUControl/md_op hold stable throughout BUSY and the out_valid cycle.
- out_valid is a 1-cycle pulse with no downstream backpressure.
- A request accepted in the cycle out_valid is high (IDLE) is legal.
- flush (sync, highest priority over accept and count): next state IDLE, counter 0, out_valid 0, busy 0. ALUControl/md_op/illegal hold their values. A request presented with flush is not accepted.
- rst_n asserted mid-BUSY: immediate return to reset values; no out_valid pulse.
- in_valid while BUSY: ignored (in_ready=0); the requester must hold it.

Test Plan:
- Reset, then ALUOp=10, funct3=000, funct7_5=1, is_imm=0 -> next cycle out_valid=1, ALUControl=0110. Same with is_imm=1 -> 0010.
- Back-to-back accepts SLTU (011), XOR (100), SRA (101, f7_5=1), AND (111) on consecutive cycles -> 1000, 1001, 1100, 0000, each on consecutive out_valid pulses.
- MUL (ALUOp=10, f3=000, f7_0=1), MUL_CYCLES=2 -> busy=1 for 2 cycles, in_ready=0, out_valid pulse at accept+3 with ALUControl=1101, md_op=000.
- DIVU (f3=101, f7_0=1), DIV_CYCLES=32 -> out_valid exactly 33 cycles after accept, ALUControl=1110, md_op=101. A request held during BUSY is accepted in the cycle after the pulse.
- Start DIV, assert flush at BUSY cycle 5 -> next cycle busy=0, in_ready=1, no out_valid. Repeat with rst_n=0 mid-BUSY -> outputs at reset values immediately.
- ALUOp=11 -> out_valid=1 with illegal=1, ALUControl=1111. OP-IMM with f7_0=1, f3=110 -> ALUControl=0001, no busy.
